// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the iterative integer square-root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic int q_width(input int width);
    return (width + 1) / 2;
  endfunction

  function automatic int iter_count(input int qw, input int rpc);
    return (qw + rpc - 1) / rpc;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit step: brings down a radical bit pair and resolves one root bit.
module sqrt_step #(
  parameter int Q_W = 8
) (
  input  logic [Q_W-1:0] root_in,
  input  logic [Q_W+1:0] rem_in,
  input  logic [1:0]     pair_in,
  input  logic           enable,
  output logic [Q_W-1:0] root_out,
  output logic [Q_W+1:0] rem_out
);

  logic [Q_W+1:0] rem_sh;
  logic [Q_W+1:0] trial;
  logic           ge;

  // Partial remainder never exceeds 2*root, so the shifted-out MSBs are always zero.
  always_comb begin
    rem_sh   = (rem_in << 2) | {{Q_W{1'b0}}, pair_in};
    trial    = {root_in, 2'b01};
    ge       = (rem_sh >= trial);
    root_out = root_in;
    rem_out  = rem_in;
    if (enable) begin
      root_out = (root_in << 1) | Q_W'(ge);
      rem_out  = ge ? (rem_sh - trial) : rem_sh;
    end
  end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative floor/round square root with valid/ready on both sides.
// ROOTS_PER_CYCLE chained digit steps run per clock in the CALC state.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int ROOTS_PER_CYCLE = 1,
  localparam int Q_W            = q_width(WIDTH),
  localparam int ITER           = iter_count(Q_W, ROOTS_PER_CYCLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_radical,
  input  logic             in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   out_q,
  output logic [Q_W:0]     out_rem,
  output logic             out_sat
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_t             state_q, state_d;
  logic [2*Q_W-1:0]   opnd_q;
  logic [Q_W-1:0]     root_q;
  logic [Q_W+1:0]     rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rnd_q;
  logic               last;
  logic               accept;

  logic [ROOTS_PER_CYCLE:0][Q_W-1:0] root_ch;
  logic [ROOTS_PER_CYCLE:0][Q_W+1:0] rem_ch;

  assign root_ch[0] = root_q;
  assign rem_ch[0]  = rem_q;

  // Steps past the last root bit pass through when Q_W is not a multiple of ROOTS_PER_CYCLE.
  for (genvar i = 0; i < ROOTS_PER_CYCLE; i++) begin : g_step
    sqrt_step #(.Q_W(Q_W)) u_step (
      .root_in  (root_ch[i]),
      .rem_in   (rem_ch[i]),
      .pair_in  (opnd_q[2*Q_W-1-2*i -: 2]),
      .enable   ((int'(cnt_q) * ROOTS_PER_CYCLE + i) < Q_W),
      .root_out (root_ch[i+1]),
      .rem_out  (rem_ch[i+1])
    );
  end

  logic [Q_W-1:0] root_fin;
  logic [Q_W+1:0] rem_fin;
  logic           round_up;
  logic           root_max;

  assign root_fin = root_ch[ROOTS_PER_CYCLE];
  assign rem_fin  = rem_ch[ROOTS_PER_CYCLE];
  // rem > q is exactly round-half-up since (q+0.5)^2 = q^2 + q + 0.25.
  assign round_up = rnd_q && (rem_fin > {2'b00, root_fin});
  assign root_max = &root_fin;
  assign last     = (cnt_q == CNT_W'(ITER - 1));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q  <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      rnd_q   <= 1'b0;
      out_q   <= '0;
      out_rem <= '0;
      out_sat <= 1'b0;
    end else if (accept) begin
      opnd_q <= (2*Q_W)'(in_radical);
      rnd_q  <= in_round;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == CALC) begin
      opnd_q <= opnd_q << (2*ROOTS_PER_CYCLE);
      root_q <= root_fin;
      rem_q  <= rem_fin;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        out_q   <= (round_up && !root_max) ? root_fin + 1'b1 : root_fin;
        out_rem <= rem_fin[Q_W:0];
        out_sat <= round_up && root_max;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: directed table, randomized sweep against an arithmetic model,
// back-to-back, stall and mid-calculation reset sequences.
module tb_sqrt_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u0: WIDTH=16 RPC=1
  logic        v0, rnd0, ordy0, irdy0, ov0, sat0;
  logic [15:0] rad0;
  logic [7:0]  q0;
  logic [8:0]  rem0;
  // u1: WIDTH=15 RPC=3, u2: WIDTH=15 RPC=8, sharing the input side
  logic        v12, rnd12, ordy1, ordy2, irdy1, irdy2, ov1, ov2, sat1, sat2;
  logic [14:0] rad12;
  logic [7:0]  q1, q2;
  logic [8:0]  rem1, rem2;

  int n_tests = 0;
  int n_fail  = 0;

  sqrt_iter #(.WIDTH(16), .ROOTS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(irdy0), .in_radical(rad0), .in_round(rnd0),
    .out_valid(ov0), .out_ready(ordy0), .out_q(q0), .out_rem(rem0), .out_sat(sat0));
  sqrt_iter #(.WIDTH(15), .ROOTS_PER_CYCLE(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(v12), .in_ready(irdy1), .in_radical(rad12), .in_round(rnd12),
    .out_valid(ov1), .out_ready(ordy1), .out_q(q1), .out_rem(rem1), .out_sat(sat1));
  sqrt_iter #(.WIDTH(15), .ROOTS_PER_CYCLE(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(v12), .in_ready(irdy2), .in_radical(rad12), .in_round(rnd12),
    .out_valid(ov2), .out_ready(ordy2), .out_q(q2), .out_rem(rem2), .out_sat(sat2));

  typedef struct {
    longint rad;
    bit     rnd;
    longint q;
    longint rem;
    bit     sat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exhaustive integer search for floor root, then the rounding rule.
  function automatic void ref_sqrt(input longint r, input bit rnd, input int qw,
                                   output longint q, output longint rem, output bit sat);
    longint f;
    f = 0;
    while ((f + 1) * (f + 1) <= r) f++;
    rem = r - f * f;
    q   = f;
    sat = 1'b0;
    if (rnd && rem > f) begin
      if (f == (longint'(1) << qw) - 1) sat = 1'b1;
      else                              q = f + 1;
    end
  endfunction

  task automatic run0(input longint rad, input bit rnd, output longint q, output longint rem,
                      output bit sat, output int lat);
    int guard;
    guard = 0;
    q = 0; rem = 0; sat = 0; lat = 0;
    while (!irdy0 && guard < 50) begin tick(); guard++; end
    if (!irdy0) begin timeout("run0_in_ready"); return; end
    v0 = 1'b1; rad0 = 16'(rad); rnd0 = rnd;
    tick();
    v0 = 1'b0;
    lat = 1;
    while (!ov0 && lat < 50) begin tick(); lat++; end
    if (!ov0) begin timeout("run0_out_valid"); return; end
    q = q0; rem = rem0; sat = sat0;
    ordy0 = 1'b1;
    tick();
    ordy0 = 1'b0;
  endtask

  task automatic run12(input longint rad, input bit rnd,
                       output longint qa, output longint rema, output bit sata, output int la,
                       output longint qb, output longint remb, output bit satb, output int lb);
    int c;
    qa = 0; rema = 0; sata = 0; la = 0;
    qb = 0; remb = 0; satb = 0; lb = 0;
    v12 = 1'b1; rad12 = 15'(rad); rnd12 = rnd;
    tick();
    v12 = 1'b0;
    c = 1;
    for (int k = 0; k < 50; k++) begin
      if (ov1 && la == 0) begin la = c; qa = q1; rema = rem1; sata = sat1; end
      if (ov2 && lb == 0) begin lb = c; qb = q2; remb = rem2; satb = sat2; end
      if (la != 0 && lb != 0) break;
      tick();
      c++;
    end
    if (la == 0) timeout("run12_u1_out_valid");
    if (lb == 0) timeout("run12_u2_out_valid");
    ordy1 = 1'b1; ordy2 = 1'b1;
    tick();
    ordy1 = 1'b0; ordy2 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t   tbl[8];
    longint q, rem, eq, erem, qb, remb;
    bit     sat, esat, satb;
    int     lat, latb;

    v0 = 0; rnd0 = 0; ordy0 = 0; rad0 = '0;
    v12 = 0; rnd12 = 0; ordy1 = 0; ordy2 = 0; rad12 = '0;

    tbl[0] = '{rad: 144,   rnd: 0, q: 12,  rem: 0,   sat: 0};
    tbl[1] = '{rad: 150,   rnd: 1, q: 12,  rem: 6,   sat: 0};
    tbl[2] = '{rad: 157,   rnd: 1, q: 13,  rem: 13,  sat: 0};
    tbl[3] = '{rad: 65535, rnd: 0, q: 255, rem: 510, sat: 0};
    tbl[4] = '{rad: 65535, rnd: 1, q: 255, rem: 510, sat: 1};
    tbl[5] = '{rad: 0,     rnd: 0, q: 0,   rem: 0,   sat: 0};
    tbl[6] = '{rad: 0,     rnd: 1, q: 0,   rem: 0,   sat: 0};
    tbl[7] = '{rad: 143,   rnd: 1, q: 12,  rem: 22,  sat: 0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_in_ready", irdy0, 1);
    check("reset_out_valid", ov0, 0);
    check("reset_out_q", q0, 0);
    check("reset_out_rem", rem0, 0);
    check("reset_out_sat", sat0, 0);

    foreach (tbl[i]) begin
      run0(tbl[i].rad, tbl[i].rnd, q, rem, sat, lat);
      check($sformatf("tbl%0d_q", i), q, tbl[i].q);
      check($sformatf("tbl%0d_rem", i), rem, tbl[i].rem);
      check($sformatf("tbl%0d_sat", i), sat, tbl[i].sat);
      check($sformatf("tbl%0d_latency", i), lat, 9);
    end

    run12(32767, 0, q, rem, sat, lat, qb, remb, satb, latb);
    check("w15_rpc3_q", q, 181);
    check("w15_rpc3_rem", rem, 6);
    check("w15_rpc3_latency", lat, 4);
    check("w15_rpc8_q", qb, 181);
    check("w15_rpc8_rem", remb, 6);
    check("w15_rpc8_latency", latb, 2);

    for (int i = 0; i < 150; i++) begin
      longint r;
      bit     rb;
      r  = (i % 6 == 0) ? 65535 - longint'($urandom_range(0, 600)) : longint'($urandom_range(0, 65535));
      rb = 1'($urandom_range(0, 1));
      ref_sqrt(r, rb, 8, eq, erem, esat);
      run0(r, rb, q, rem, sat, lat);
      check($sformatf("rnd16_%0d_q(r=%0d)", i, r), q, eq);
      check($sformatf("rnd16_%0d_rem(r=%0d)", i, r), rem, erem);
      check($sformatf("rnd16_%0d_sat(r=%0d)", i, r), sat, esat);
    end

    for (int i = 0; i < 40; i++) begin
      longint r;
      bit     rb;
      r  = longint'($urandom_range(0, 32767));
      rb = 1'($urandom_range(0, 1));
      ref_sqrt(r, rb, 8, eq, erem, esat);
      run12(r, rb, q, rem, sat, lat, qb, remb, satb, latb);
      check($sformatf("rnd15a_%0d_q(r=%0d)", i, r), q, eq);
      check($sformatf("rnd15a_%0d_rem(r=%0d)", i, r), rem, erem);
      check($sformatf("rnd15b_%0d_q(r=%0d)", i, r), qb, eq);
      check($sformatf("rnd15b_%0d_rem(r=%0d)", i, r), remb, erem);
      check($sformatf("rnd15b_%0d_sat(r=%0d)", i, r), satb, esat);
    end

    // Back-to-back: 100..103 accepted as fast as the unit allows, results in order.
    begin
      int     acc, got;
      longint nxt;
      bit     taken;
      acc = 0; got = 0; nxt = 100;
      ordy0 = 1'b1;
      for (int k = 0; k < 200 && got < 4; k++) begin
        rad0 = 16'(nxt); rnd0 = 1'b0; v0 = (acc < 4);
        if (ov0) begin
          check($sformatf("b2b%0d_q", got), q0, 10);
          check($sformatf("b2b%0d_rem", got), rem0, got);
          check($sformatf("b2b%0d_in_ready", got), irdy0, 1);
          got++;
        end
        taken = v0 && irdy0;
        if (taken) acc++;
        tick();
        if (taken) nxt++;
      end
      if (got < 4) timeout("b2b_results");
      v0 = 1'b0; ordy0 = 1'b0;
      tick();
    end

    // Stall: result held with out_ready low; extra in_valid must be ignored.
    begin
      int guard;
      v0 = 1'b1; rad0 = 16'd200; rnd0 = 1'b0;
      tick();
      rad0 = 16'd999;
      guard = 0;
      while (!ov0 && guard < 50) begin tick(); guard++; end
      if (!ov0) timeout("stall_out_valid");
      for (int k = 0; k < 5; k++) begin
        check($sformatf("stall%0d_valid", k), ov0, 1);
        check($sformatf("stall%0d_q", k), q0, 14);
        check($sformatf("stall%0d_rem", k), rem0, 4);
        check($sformatf("stall%0d_in_ready", k), irdy0, 0);
        tick();
      end
      v0 = 1'b0; ordy0 = 1'b1;
      tick();
      ordy0 = 1'b0;
      check("stall_release_valid", ov0, 0);
    end

    // Reset during the 4th CALC cycle drops the transaction.
    begin
      bit seen;
      v0 = 1'b1; rad0 = 16'd1000; rnd0 = 1'b0;
      tick();
      v0 = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", ov0, 0);
      check("midrst_in_ready", irdy0, 1);
      seen = 1'b0;
      repeat (12) begin tick(); if (ov0) seen = 1'b1; end
      check("midrst_no_pulse", seen, 0);
      run0(81, 0, q, rem, sat, lat);
      check("midrst_next_q", q, 9);
      check("midrst_next_rem", rem, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
